// File: rtl/lsu_mem_ctrl_if.sv
// CPU-side request/response channel of the load/store unit.
//
// Signals:
//   req_valid  request present
//   req_ready  request accepted when req_valid & req_ready
//   req_we     1 = store, 0 = load
//   req_funct3 RV32I access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_addr   byte address
//   req_wdata  store data, right-aligned
//   resp_valid one-cycle response pulse, no backpressure
//   resp_err   qualifies resp_valid: access rejected, memory untouched
//   resp_rdata extended load data; 0 for stores and errors
//
// Modports:
//   master  CPU memory stage (drives requests)
//   slave   load/store unit (drives ready and responses)
interface lsu_mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;

  modport master (
    output req_valid,
    output req_we,
    output req_funct3,
    output req_addr,
    output req_wdata,
    input  req_ready,
    input  resp_valid,
    input  resp_err,
    input  resp_rdata
  );

  modport slave (
    input  req_valid,
    input  req_we,
    input  req_funct3,
    input  req_addr,
    input  req_wdata,
    output req_ready,
    output resp_valid,
    output resp_err,
    output resp_rdata
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit between the CPU memory stage and a byte-addressed data bram.
//
// Accepts one request at a time, validates funct3, store signedness and address
// range, then drives one bram access cycle. Loads wait for the bram's registered
// douta, extend it and return it; every request ends with a one-cycle response.
//
// Optional feature: define LSU_MISALIGN_TRAP_EN to reject misaligned halfword and
// word accesses (they go straight to the response with resp_err set). Without it,
// misaligned accesses go to the bram, which handles arbitrary byte addresses.
//
// Parameters:
//   ADDR_W  bram byte-address width; legal addresses are 0 .. 2**ADDR_W-1
//
// Ports:
//   clk    clock, rising edge
//   rst    asynchronous reset, active-low
//   bus    request/response channel (slave side)
//   wena   bram write enable (only in the access cycle of a store)
//   ba     bram byte access flag
//   ha     bram halfword access flag
//   ua     bram unsigned flag (funct3[2])
//   addra  bram byte address
//   dina   bram write data
//   douta  bram read data, valid the cycle after the read cycle
module lsu_mem_ctrl #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  lsu_mem_ctrl_if.slave     bus,
  output logic              wena,
  output logic              ba,
  output logic              ha,
  output logic              ua,
  output logic [ADDR_W-1:0] addra,
  output logic [31:0]       dina,
  input  logic [31:0]       douta
);

  localparam int unsigned AddrW1 = ADDR_W + 1;

  localparam logic [2:0] Funct3B  = 3'b000;
  localparam logic [2:0] Funct3H  = 3'b001;
  localparam logic [2:0] Funct3W  = 3'b010;
  localparam logic [2:0] Funct3Bu = 3'b100;
  localparam logic [2:0] Funct3Hu = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StCapture,
    StResp
  } state_e;

  state_e            state_q;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              resp_err_q;
  logic [31:0]       resp_rdata_q;

  // ---------------------------------------------------------------------------
  // Request validation (combinational on the incoming request)
  // ---------------------------------------------------------------------------
  logic [1:0]    size_m1;
  logic          funct3_legal;
  logic [ADDR_W:0] last_byte;
  logic          high_bits_err;
  logic          range_err;
  logic          store_sign_err;
  logic          misalign_err;
  logic          req_err;

  always_comb begin
    size_m1      = 2'd0;
    funct3_legal = 1'b0;
    case (bus.req_funct3)
      Funct3B, Funct3Bu: begin
        size_m1      = 2'd0;
        funct3_legal = 1'b1;
      end
      Funct3H, Funct3Hu: begin
        size_m1      = 2'd1;
        funct3_legal = 1'b1;
      end
      Funct3W: begin
        size_m1      = 2'd3;
        funct3_legal = 1'b1;
      end
      default: begin
        size_m1      = 2'd0;
        funct3_legal = 1'b0;
      end
    endcase
  end

  // One extra bit catches the last byte of the access running past the top address.
  assign last_byte      = {1'b0, bus.req_addr[ADDR_W-1:0]} + AddrW1'(size_m1);
  assign high_bits_err  = (bus.req_addr[31:ADDR_W] != '0);
  assign range_err      = high_bits_err || last_byte[ADDR_W];
  // There is no unsigned store.
  assign store_sign_err = bus.req_we && bus.req_funct3[2];

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_err = ((size_m1 == 2'd1) && bus.req_addr[0]) ||
                        ((size_m1 == 2'd3) && (bus.req_addr[1:0] != 2'b00));
`else
  assign misalign_err = 1'b0;
`endif

  assign req_err = !funct3_legal || store_sign_err || range_err || misalign_err;

  // ---------------------------------------------------------------------------
  // Load data extension from the low lanes of douta
  // ---------------------------------------------------------------------------
  logic [31:0] load_ext;

  always_comb begin
    case (funct3_q)
      Funct3B:  load_ext = {{24{douta[7]}}, douta[7:0]};
      Funct3H:  load_ext = {{16{douta[15]}}, douta[15:0]};
      Funct3Bu: load_ext = {24'h000000, douta[7:0]};
      Funct3Hu: load_ext = {16'h0000, douta[15:0]};
      default:  load_ext = douta;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM and request/response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            we_q         <= bus.req_we;
            funct3_q     <= bus.req_funct3;
            addr_q       <= bus.req_addr[ADDR_W-1:0];
            wdata_q      <= bus.req_wdata;
            resp_err_q   <= req_err;
            // Stores and errors respond with zero; loads overwrite in StCapture.
            resp_rdata_q <= 32'h0;
            state_q      <= req_err ? StResp : StAccess;
          end
        end
        StAccess: begin
          state_q <= we_q ? StResp : StCapture;
        end
        StCapture: begin
          resp_rdata_q <= load_ext;
          state_q      <= StResp;
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from the state register so reset clears them at once
  // ---------------------------------------------------------------------------
  logic in_access;

  assign in_access      = (state_q == StAccess);

  assign bus.req_ready  = (state_q == StIdle);
  assign bus.resp_valid = (state_q == StResp);
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;

  assign wena  = in_access && we_q;
  assign ba    = in_access && (funct3_q[1:0] == 2'b00);
  assign ha    = in_access && (funct3_q[1:0] == 2'b01);
  assign ua    = in_access && funct3_q[2];
  assign addra = in_access ? addr_q : '0;
  assign dina  = in_access ? wdata_q : 32'h0;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed requests, a transaction-level reference model
// (byte array plus latency/response rules) and a per-cycle compare process.
module tb_lsu_mem_ctrl;

  localparam int unsigned AW       = 10;
  localparam int          MemBytes = 1 << AW;

  logic          clk;
  logic          rst;
  logic          wena;
  logic          ba;
  logic          ha;
  logic          ua;
  logic [AW-1:0] addra;
  logic [31:0]   dina;
  logic [31:0]   douta;

  lsu_mem_ctrl_if bus ();

  lsu_mem_ctrl #(
    .ADDR_W (AW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .wena  (wena),
    .ba    (ba),
    .ha    (ha),
    .ua    (ua),
    .addra (addra),
    .dina  (dina),
    .douta (douta)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Bram: byte array, registered 4-byte read starting at addra
  // ---------------------------------------------------------------------------
  logic [7:0] mem [0:MemBytes-1];

  initial begin
    for (int i = 0; i < MemBytes; i++) mem[i] = 8'h00;
    douta = 32'h0;
    forever begin
      @(posedge clk);
      douta <= {mem[addra + 10'd3], mem[addra + 10'd2], mem[addra + 10'd1], mem[addra]};
      if (wena) begin
        mem[addra] = dina[7:0];
        if (!ba) mem[addra + 10'd1] = dina[15:8];
        if (!ba && !ha) begin
          mem[addra + 10'd2] = dina[23:16];
          mem[addra + 10'd3] = dina[31:24];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [7:0] ref_mem [0:MemBytes-1];

  initial for (int i = 0; i < MemBytes; i++) ref_mem[i] = 8'h00;

  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit model_err(input bit we, input logic [2:0] f3, input logic [31:0] addr);
    longint a;
    int     sz;
    a  = longint'(addr);
    sz = size_of(f3);
    if (sz == 0) return 1'b1;
    if (we && f3[2]) return 1'b1;
    if (a + sz > MemBytes) return 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
    if ((a % sz) != 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
    logic [31:0] v;
    int          sz;
    sz = size_of(f3);
    v  = 32'h0;
    for (int i = 0; i < sz; i++) v = v | (32'(ref_mem[int'(addr) + i]) << (8 * i));
    if (!f3[2] && sz < 4 && v[8 * sz - 1]) v = v | ~((32'd1 << (8 * sz)) - 32'd1);
    return v;
  endfunction

  // Expected transaction currently in flight
  bit          pending       = 1'b0;
  int          exp_at        = -1;
  int          exp_acc_at    = -1;
  int          last_resp_cyc = -1;
  bit          exp_err;
  bit          exp_we;
  logic [31:0] exp_rdata;
  logic [31:0] exp_addra;
  logic [31:0] exp_dina;
  bit          exp_ba;
  bit          exp_ha;
  bit          exp_ua;
  logic        got_err;
  logic [31:0] got_rdata;

  // ---------------------------------------------------------------------------
  // Per-cycle compare
  // ---------------------------------------------------------------------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        bit resp_exp;
        bit acc_exp;
        resp_exp = pending && (cyc == exp_at);
        acc_exp  = pending && (cyc == exp_acc_at);
        chk("req_ready", 32'(bus.req_ready), 32'(!pending));
        chk("resp_valid", 32'(bus.resp_valid), 32'(resp_exp));
        chk("wena", 32'(wena), 32'(acc_exp && exp_we));
        if (acc_exp) begin
          chk("addra", 32'(addra), exp_addra);
          chk("dina", dina, exp_dina);
          chk("ba", 32'(ba), 32'(exp_ba));
          chk("ha", 32'(ha), 32'(exp_ha));
          chk("ua", 32'(ua), 32'(exp_ua));
        end
        if (resp_exp) begin
          got_err   = bus.resp_err;
          got_rdata = bus.resp_rdata;
          chk("resp_err", 32'(bus.resp_err), 32'(exp_err));
          chk("resp_rdata", bus.resp_rdata, exp_rdata);
          pending       = 1'b0;
          last_resp_cyc = cyc;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input bit upd);
    int n;
    int sz;
    n = 0;
    @(negedge clk);
    #1;
    while ((pending || cyc <= last_resp_cyc) && n < 30) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (pending) begin
      chk("idle_timeout", 32'(pending), 32'd0);
      pending = 1'b0;
    end
    sz        = size_of(f3);
    exp_err   = model_err(we, f3, addr);
    exp_we    = we;
    exp_addra = addr & (MemBytes - 1);
    exp_dina  = wd;
    exp_ba    = (sz == 1);
    exp_ha    = (sz == 2);
    exp_ua    = f3[2];
    if (exp_err || we) exp_rdata = 32'h0;
    else               exp_rdata = model_load(f3, addr);
    if (!exp_err && we && upd) begin
      for (int i = 0; i < sz; i++) ref_mem[int'(addr) + i] = wd[8 * i +: 8];
    end
    exp_at     = cyc + (exp_err ? 1 : (we ? 2 : 3));
    exp_acc_at = exp_err ? -1 : cyc + 1;
    pending    = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  // Issue, wait for the response and pin it to hand-computed literals.
  task automatic run(input string name, input bit we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input bit lit_err, input logic [31:0] lit_rdata);
    int n;
    issue(we, f3, addr, wd, 1'b1);
    n = 0;
    while (pending && n < 30) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (pending) begin
      chk({name, ".resp_timeout"}, 32'(pending), 32'd0);
      pending = 1'b0;
    end else begin
      chk({name, ".err"}, 32'(got_err), 32'(lit_err));
      chk({name, ".rdata"}, got_rdata, lit_rdata);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    rst            = 1'b0;
    #1;
    chk("rst.req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst.resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst.resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst.wena", 32'(wena), 32'd0);
    chk("rst.flags", {29'd0, ba, ha, ua}, 32'd0);
    chk("rst.addra", 32'(addra), 32'd0);
    chk("rst.dina", dina, 32'd0);
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;

    run("sw_010",  1'b1, 3'b010, 32'h010, 32'hDEADBEEF, 1'b0, 32'h0);
    run("lw_010",  1'b0, 3'b010, 32'h010, 32'h0, 1'b0, 32'hDEADBEEF);
    run("lb_013",  1'b0, 3'b000, 32'h013, 32'h0, 1'b0, 32'hFFFFFFDE);
    run("lbu_013", 1'b0, 3'b100, 32'h013, 32'h0, 1'b0, 32'h000000DE);
    run("lh_010",  1'b0, 3'b001, 32'h010, 32'h0, 1'b0, 32'hFFFFBEEF);
    run("lhu_012", 1'b0, 3'b101, 32'h012, 32'h0, 1'b0, 32'h0000DEAD);
    run("lw_3fd",  1'b0, 3'b010, 32'h3FD, 32'h0, 1'b1, 32'h0);
    run("sb_400",  1'b1, 3'b000, 32'h400, 32'h000000FF, 1'b1, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    run("lh_011",  1'b0, 3'b001, 32'h011, 32'h0, 1'b1, 32'h0);
`else
    run("lh_011",  1'b0, 3'b001, 32'h011, 32'h0, 1'b0, 32'hFFFFADBE);
`endif
    run("f3_011",  1'b0, 3'b011, 32'h010, 32'h0, 1'b1, 32'h0);
    run("sbu",     1'b1, 3'b100, 32'h010, 32'h11, 1'b1, 32'h0);
    run("f3_110",  1'b0, 3'b110, 32'h010, 32'h0, 1'b1, 32'h0);
    run("f3_111",  1'b1, 3'b111, 32'h010, 32'h0, 1'b1, 32'h0);
    run("lw_high", 1'b0, 3'b010, 32'h00010010, 32'h0, 1'b1, 32'h0);
    run("lw_010b", 1'b0, 3'b010, 32'h010, 32'h0, 1'b0, 32'hDEADBEEF);

    // Top-of-memory boundary
    run("sh_3fe",  1'b1, 3'b001, 32'h3FE, 32'h00008001, 1'b0, 32'h0);
    run("lh_3fe",  1'b0, 3'b001, 32'h3FE, 32'h0, 1'b0, 32'hFFFF8001);
    run("lw_3fc",  1'b0, 3'b010, 32'h3FC, 32'h0, 1'b0, 32'h80010000);
    run("lb_3ff",  1'b0, 3'b000, 32'h3FF, 32'h0, 1'b0, 32'hFFFFFF80);
    run("lhu_3ff", 1'b0, 3'b101, 32'h3FF, 32'h0, 1'b1, 32'h0);

    // Byte store only touches one lane
    run("sb_005",  1'b1, 3'b000, 32'h005, 32'h112233A5, 1'b0, 32'h0);
    run("lbu_005", 1'b0, 3'b100, 32'h005, 32'h0, 1'b0, 32'h000000A5);
    run("lw_004",  1'b0, 3'b010, 32'h004, 32'h0, 1'b0, 32'h0000A500);
`ifdef LSU_MISALIGN_TRAP_EN
    run("lw_005",  1'b0, 3'b010, 32'h005, 32'h0, 1'b1, 32'h0);
`else
    run("lw_005",  1'b0, 3'b010, 32'h005, 32'h0, 1'b0, 32'h000000A5);
`endif

    // Reset during the access cycle of a store drops it
    run("sw_020",  1'b1, 3'b010, 32'h020, 32'hCAFEF00D, 1'b0, 32'h0);
    issue(1'b1, 3'b010, 32'h020, 32'h12345678, 1'b0);
    #1;
    chk("abort.pre_wena", 32'(wena), 32'd1);
    rst = 1'b0;
    #1;
    chk("abort.wena", 32'(wena), 32'd0);
    chk("abort.req_ready", 32'(bus.req_ready), 32'd1);
    chk("abort.resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("abort.resp_err", 32'(bus.resp_err), 32'd0);
    chk("abort.resp_rdata", bus.resp_rdata, 32'd0);
    chk("abort.flags", {29'd0, ba, ha, ua}, 32'd0);
    chk("abort.addra", 32'(addra), 32'd0);
    chk("abort.dina", dina, 32'd0);
    pending    = 1'b0;
    exp_acc_at = -1;
    exp_at     = -1;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
    run("lw_020",  1'b0, 3'b010, 32'h020, 32'h0, 1'b0, 32'hCAFEF00D);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
